rv32i_fetch_stage: RTL and testbench

//  Instruction fetch stage directly upstream of the RV32I decoder. Generates the PC, issues

---
 rtl/rv32_pkg.sv | 13 +
 rtl/rv32i_fetch_stage_if.sv | 33 +++
 rtl/fetch_queue.sv | 57 +++++
 rtl/rv32i_fetch_stage.sv | 117 +++++++++++
 tb/tb_rv32i_fetch_stage.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package rv32_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/rv32i_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect and decode handshake.
// master = fetch stage, slave = memory/decode environment.
interface rv32i_fetch_stage_if #(
  parameter int size = 32
);
  logic            imem_req_o;
  logic [size-1:0] imem_addr_o;
  logic            imem_ready_i;
  logic            imem_rvalid_i;
  logic [size-1:0] imem_rdata_i;
  logic            redirect_i;
  logic [size-1:0] redirect_pc_i;
  logic            instr_valid_o;
  logic            instr_ready_i;
  logic [size-1:0] instruction_o;
  logic [size-1:0] pc_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_ready_i, imem_rvalid_i, imem_rdata_i,
    input  redirect_i, redirect_pc_i,
    output instr_valid_o, instruction_o, pc_o,
    input  instr_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_ready_i, imem_rvalid_i, imem_rdata_i,
    output redirect_i, redirect_pc_i,
    input  instr_valid_o, instruction_o, pc_o,
    output instr_ready_i
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction queue of {pc, instruction}; flush wins over push, push+pop same cycle both apply.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_head_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == DEPTH[AW:0]);
  assign o_count     = r_count;
  assign o_head_data = r_mem[r_rd_ptr];
  assign w_pop       = i_pop & ~o_empty;
  assign w_push      = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/rv32i_fetch_stage.sv
// RV32I fetch stage: PC generation, credit-limited imem requests, in-order queue toward decode.
// FETCH_TRACE_EN adds a tracer_interface.source port reporting each instruction handed to decode.
//   state | meaning
//   IDLE  | one cycle after reset release, no requests
//   FETCH | issuing requests, responses pushed into the queue
//   FLUSH | after a redirect, discarding responses still in flight
module rv32i_fetch_stage
  import rv32_pkg::*;
#(
  parameter int              size        = 32,
  parameter logic [size-1:0] RESET_PC    = size'(DEFAULT_RESET_PC),
  parameter int              QUEUE_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  rv32i_fetch_stage_if.master  bus
`ifdef FETCH_TRACE_EN
  ,
  tracer_interface.source      tracer_if_o
`endif
);
  localparam int              CW      = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_C = QUEUE_DEPTH[CW:0];
  localparam logic [size-1:0] PC_STEP = size'(4);

  fetch_state_t      r_state;
  logic [size-1:0]   r_fetch_pc;
  logic [size-1:0]   r_resp_pc;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_drop;

  logic [CW-1:0]     w_count;
  logic              w_empty;
  logic              w_full;
  logic [CW:0]       w_inflight;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [size-1:0]   w_redirect_pc;
  logic [2*size-1:0] w_head;

  assign w_redirect_pc   = bus.redirect_pc_i & ~size'(3);
  assign w_inflight      = {1'b0, w_count} + {1'b0, r_outstanding};
  // Queue slots are reserved at request time, so a response can always be pushed.
  assign bus.imem_req_o  = (r_state == FETCH) & ~bus.redirect_i & ~w_full & (w_inflight < DEPTH_C);
  assign bus.imem_addr_o = r_fetch_pc;
  assign w_accept        = bus.imem_req_o & bus.imem_ready_i;
  assign w_push          = (r_state == FETCH) & bus.imem_rvalid_i & ~bus.redirect_i;
  assign w_pop           = ~w_empty & bus.instr_ready_i & ~bus.redirect_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      case (r_state)
        IDLE: r_state <= FETCH;
        FETCH: begin
          if (bus.redirect_i && r_outstanding != '0) begin
            r_state <= FLUSH;
            // A response arriving with the redirect is already consumed here.
            r_drop  <= r_outstanding - CW'(bus.imem_rvalid_i);
          end
        end
        FLUSH: begin
          if (bus.imem_rvalid_i && r_drop != '0) r_drop <= r_drop - 1'b1;
          if (r_drop == '0 && !bus.redirect_i) r_state <= FETCH;
        end
        default: r_state <= IDLE;
      endcase

      if (bus.redirect_i) begin
        r_fetch_pc    <= w_redirect_pc;
        r_resp_pc     <= w_redirect_pc;
        r_outstanding <= '0;
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + PC_STEP;
        if (w_push)   r_resp_pc  <= r_resp_pc + PC_STEP;
        case ({w_accept, w_push})
          2'b10:   r_outstanding <= r_outstanding + 1'b1;
          2'b01:   r_outstanding <= r_outstanding - 1'b1;
          default: r_outstanding <= r_outstanding;
        endcase
      end
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (2*size)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data ({r_resp_pc, bus.imem_rdata_i}),
    .i_pop       (w_pop),
    .i_flush     (bus.redirect_i),
    .o_head_data (w_head),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  assign bus.instr_valid_o = ~w_empty;
  assign bus.instruction_o = w_empty ? size'(NOP_INSTR) : w_head[size-1:0];
  assign bus.pc_o          = w_empty ? RESET_PC : w_head[2*size-1:size];

`ifdef FETCH_TRACE_EN
  assign tracer_if_o.valid = bus.instr_valid_o & bus.instr_ready_i;
  assign tracer_if_o.pc    = bus.pc_o;
  assign tracer_if_o.instr = bus.instruction_o;
`endif

endmodule

// File: tb/tb_rv32i_fetch_stage.sv
// Self-checking bench for rv32i_fetch_stage: randomized memory/decode timing against a PC-stream model.
module tb_rv32i_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rv32i_fetch_stage_if #(.size(32)) ifc ();

  rv32i_fetch_stage #(
    .size        (32),
    .RESET_PC    (RST_PC),
    .QUEUE_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int errors = 0;
  int checks = 0;
  int ready_pct = 100;
  int resp_pct = 100;
  int dec_pct = 100;
  int pops = 0;
  int accepts = 0;
  int cyc = 0;
  int first_acc_cyc = -1;
  int first_pop_cyc = -1;
  bit first_pop_seen = 1'b0;
  logic [31:0] first_pop_pc = '0;
  logic [31:0] exp_fetch = RST_PC;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] mem_q[$];

  // Memory content: bijective scramble of the address so every word identifies its PC.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_1000;
  endfunction

  // One clock cycle: drive at start, observe and update the reference at the falling edge.
  task automatic step(input bit redir = 1'b0, input logic [31:0] rpc = 32'h0);
    ifc.redirect_i    = redir;
    ifc.redirect_pc_i = rpc;
    ifc.imem_ready_i  = (int'($urandom_range(99)) < ready_pct);
    ifc.instr_ready_i = (int'($urandom_range(99)) < dec_pct);
    if (mem_q.size() > 0 && int'($urandom_range(99)) < resp_pct) begin
      ifc.imem_rvalid_i = 1'b1;
      ifc.imem_rdata_i  = mem_word(mem_q[0]);
    end else begin
      ifc.imem_rvalid_i = 1'b0;
      ifc.imem_rdata_i  = $urandom;
    end
    @(negedge clk);
    if (ifc.imem_rvalid_i) void'(mem_q.pop_front());
    if (ifc.redirect_i) begin
      checks++;
      if (ifc.imem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL req_during_redirect: imem_req_o=%b required 0", ifc.imem_req_o);
      end
      exp_fetch = {rpc[31:2], 2'b00};
      exp_pc    = exp_fetch;
    end else begin
      if (ifc.instr_valid_o === 1'b1 && ifc.instr_ready_i) begin
        checks++;
        if (ifc.pc_o !== exp_pc || ifc.instruction_o !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL pop: pc=%h instr=%h required pc=%h instr=%h",
                   ifc.pc_o, ifc.instruction_o, exp_pc, mem_word(exp_pc));
        end
        if (!first_pop_seen) begin
          first_pop_seen = 1'b1;
          first_pop_pc   = ifc.pc_o;
          first_pop_cyc  = cyc;
        end
        exp_pc += 32'd4;
        pops++;
      end
      if (ifc.imem_req_o === 1'b1 && ifc.imem_ready_i) begin
        checks++;
        if (ifc.imem_addr_o !== exp_fetch) begin
          errors++;
          $display("FAIL accept_addr: addr=%h required %h", ifc.imem_addr_o, exp_fetch);
        end
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        mem_q.push_back(ifc.imem_addr_o);
        exp_fetch += 32'd4;
        accepts++;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    ifc.redirect_i = 1'b0;
  endtask

  task automatic quiet_inputs();
    ifc.imem_ready_i  = 1'b0;
    ifc.imem_rvalid_i = 1'b0;
    ifc.imem_rdata_i  = '0;
    ifc.redirect_i    = 1'b0;
    ifc.redirect_pc_i = '0;
    ifc.instr_ready_i = 1'b0;
  endtask

  task automatic release_reset();
    mem_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset          = 1'b0;
    exp_fetch      = RST_PC;
    exp_pc         = RST_PC;
    first_pop_seen = 1'b0;
    first_acc_cyc  = -1;
  endtask

  task automatic test_reset();
    quiet_inputs();
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (ifc.imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", ifc.imem_req_o); end
    if (ifc.imem_addr_o !== RST_PC) begin errors++; $display("FAIL reset_addr: got %h required %h", ifc.imem_addr_o, RST_PC); end
    if (ifc.instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", ifc.instr_valid_o); end
    if (ifc.instruction_o !== NOP) begin errors++; $display("FAIL reset_instr: got %h required %h", ifc.instruction_o, NOP); end
    if (ifc.pc_o !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h required %h", ifc.pc_o, RST_PC); end
    release_reset();
    checks++;
    if (ifc.imem_req_o !== 1'b0) begin errors++; $display("FAIL idle_req: got %b required 0", ifc.imem_req_o); end
  endtask

  task automatic test_stream();
    int p0;
    ready_pct = 100; resp_pct = 100; dec_pct = 100;
    step();
    checks++;
    if (ifc.imem_req_o !== 1'b1 || ifc.imem_addr_o !== RST_PC) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h required 1 %h", ifc.imem_req_o, ifc.imem_addr_o, RST_PC);
    end
    p0 = pops;
    repeat (30) step();
    checks += 3;
    if (pops - p0 < 25) begin errors++; $display("FAIL stream_rate: pops=%0d required >=25", pops - p0); end
    if (!first_pop_seen || first_pop_pc !== RST_PC) begin
      errors++; $display("FAIL stream_first_pc: seen=%b pc=%h required %h", first_pop_seen, first_pop_pc, RST_PC);
    end
    if (first_pop_cyc - first_acc_cyc != 2) begin
      errors++; $display("FAIL rvalid_latency: accept->pop=%0d cycles required 2", first_pop_cyc - first_acc_cyc);
    end
  endtask

  task automatic test_backpressure();
    int a0, p0;
    ready_pct = 100; resp_pct = 100; dec_pct = 0;
    repeat (20) step();
    a0 = accepts;
    repeat (5) step();
    checks += 3;
    if (accepts != a0) begin errors++; $display("FAIL full_no_req: accepts=%0d required 0", accepts - a0); end
    if (ifc.imem_req_o !== 1'b0) begin errors++; $display("FAIL full_req: got %b required 0", ifc.imem_req_o); end
    if (ifc.instr_valid_o !== 1'b1) begin errors++; $display("FAIL full_valid: got %b required 1", ifc.instr_valid_o); end
    ready_pct = 0; dec_pct = 100;
    p0 = pops;
    repeat (10) step();
    checks++;
    if (pops - p0 != 4) begin errors++; $display("FAIL queued_words: pops=%0d required 4", pops - p0); end
    ready_pct = 100;
    p0 = pops;
    repeat (20) step();
    checks++;
    if (pops - p0 < 10) begin errors++; $display("FAIL refill: pops=%0d required >=10", pops - p0); end
  endtask

  task automatic setup_two_outstanding();
    ready_pct = 0; resp_pct = 100; dec_pct = 100;
    repeat (8) step();
    resp_pct = 0; ready_pct = 100;
    repeat (2) step();
    checks++;
    if (mem_q.size() != 2) begin errors++; $display("FAIL outstanding_setup: outstanding=%0d required 2", mem_q.size()); end
  endtask

  task automatic test_redirect();
    int n;
    setup_two_outstanding();
    step(1'b1, 32'h0000_0100);
    resp_pct = 100;
    first_pop_seen = 1'b0;
    n = 0;
    while (ifc.imem_req_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n < 2 || n >= 20) begin errors++; $display("FAIL flush_len: cycles=%0d required 2..19", n); end
    repeat (15) step();
    checks++;
    if (!first_pop_seen || first_pop_pc !== 32'h0000_0100) begin
      errors++; $display("FAIL redirect_pc: seen=%b pc=%h required 00000100", first_pop_seen, first_pop_pc);
    end
  endtask

  task automatic test_redirect_in_flush();
    setup_two_outstanding();
    step(1'b1, 32'h0000_0100);
    step();
    step(1'b1, 32'h0000_0200);
    resp_pct = 100;
    first_pop_seen = 1'b0;
    repeat (25) step();
    checks++;
    if (!first_pop_seen || first_pop_pc !== 32'h0000_0200) begin
      errors++; $display("FAIL redirect2_pc: seen=%b pc=%h required 00000200", first_pop_seen, first_pop_pc);
    end
  endtask

  task automatic test_ready_stall();
    logic [31:0] a0;
    ready_pct = 100; resp_pct = 100; dec_pct = 100;
    repeat (6) step();
    a0 = ifc.imem_addr_o;
    ready_pct = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ifc.imem_req_o !== 1'b1 || ifc.imem_addr_o !== a0) begin
        errors++; $display("FAIL addr_hold: req=%b addr=%h required 1 %h", ifc.imem_req_o, ifc.imem_addr_o, a0);
      end
    end
    ready_pct = 100;
    step();
    checks++;
    if (ifc.imem_addr_o !== a0 + 32'd4) begin
      errors++; $display("FAIL pc_advance: addr=%h required %h", ifc.imem_addr_o, a0 + 32'd4);
    end
  endtask

  task automatic test_misaligned_and_reset();
    int p0;
    ready_pct = 100; resp_pct = 100; dec_pct = 100;
    step(1'b1, 32'h0000_0103);
    first_pop_seen = 1'b0;
    repeat (12) step();
    checks++;
    if (!first_pop_seen || first_pop_pc !== 32'h0000_0100) begin
      errors++; $display("FAIL misaligned_pc: seen=%b pc=%h required 00000100", first_pop_seen, first_pop_pc);
    end
    dec_pct = 0;
    repeat (3) step();
    checks++;
    if (ifc.instr_valid_o !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b required 1", ifc.instr_valid_o); end
    quiet_inputs();
    reset = 1'b1;
    #1;
    checks++;
    if ({ifc.imem_req_o, ifc.imem_addr_o, ifc.instr_valid_o, ifc.instruction_o, ifc.pc_o} !==
        {1'b0, RST_PC, 1'b0, NOP, RST_PC}) begin
      errors++;
      $display("FAIL midreset_outputs: req=%b addr=%h valid=%b instr=%h pc=%h required 0 %h 0 %h %h",
               ifc.imem_req_o, ifc.imem_addr_o, ifc.instr_valid_o, ifc.instruction_o, ifc.pc_o, RST_PC, NOP, RST_PC);
    end
    release_reset();
    dec_pct = 100;
    p0 = pops;
    repeat (16) step();
    checks++;
    if (!first_pop_seen || first_pop_pc !== RST_PC || pops - p0 < 10) begin
      errors++; $display("FAIL post_reset_stream: pc=%h pops=%0d required %h >=10", first_pop_pc, pops - p0, RST_PC);
    end
  endtask

  task automatic test_random();
    int p0;
    bit redir;
    p0 = pops;
    step(1'b1, 32'hFFFF_FFF9);
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        ready_pct = int'($urandom_range(100, 30));
        resp_pct  = int'($urandom_range(100, 30));
        dec_pct   = int'($urandom_range(100, 30));
      end
      redir = (int'($urandom_range(99)) < 3);
      step(redir, $urandom);
    end
    ready_pct = 100; resp_pct = 100; dec_pct = 100;
    repeat (20) step();
    checks++;
    if (pops - p0 < 100) begin errors++; $display("FAIL random_progress: pops=%0d required >=100", pops - p0); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_in_flush();
    test_ready_stall();
    test_misaligned_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
